// File: rtl/rc5_key_expand.sv
// RC5-16/r/16 key schedule: expands a 128-bit key into S[0..2r+1].
// One INIT word per cycle, then one MIX iteration per cycle.
module rc5_key_expand #(
  parameter int MAX_ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   num_rounds,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [5:0]   rd_addr,
  output logic [15:0]  rd_data
);

  localparam int TAB = 2 * MAX_ROUNDS + 2;
  localparam logic [15:0] P = 16'hB7E1;
  localparam logic [15:0] Q = 16'h9E37;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    MIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0] s_tab [TAB];
  logic [15:0] l_tab [8];
  logic [5:0]  t_q;
  logic [6:0]  n_q;
  logic [5:0]  i_q;
  logic [2:0]  j_q;
  logic [6:0]  k_q;
  logic [15:0] a_q, b_q, sum_q;
  logic        kv_q;

  logic [4:0]  r_c;
  logic [5:0]  t_in, t_min;
  logic [6:0]  n_in;
  logic        init_last, mix_last;
  logic [15:0] a_sum, a_new, ab, b_sum, b_new;

  function automatic logic [15:0] rotl(
    input logic [15:0] x,
    input logic [3:0]  s
  );
    logic [31:0] d;
    d = {x, x} << s;
    return d[31:16];
  endfunction

  assign r_c   = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS)
                                               : num_rounds;
  assign t_in  = {r_c, 1'b0} + 6'd2;
  assign t_min = (t_in < 6'd8) ? 6'd8 : t_in;
  assign n_in  = {1'b0, t_min} + {t_min, 1'b0};

  assign init_last = (i_q == t_q - 6'd1);
  assign mix_last  = (k_q == n_q - 7'd1);

  always_comb begin
    a_sum = s_tab[i_q] + a_q + b_q;
    a_new = rotl(a_sum, 4'd3);
    ab    = a_new + b_q;
    b_sum = l_tab[j_q] + ab;
    b_new = rotl(b_sum, ab[3:0]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = INIT;
      INIT: if (init_last) state_d = MIX;
      MIX:  if (mix_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start)
        kv_q <= 1'b0;
      else if (state_q == MIX && mix_last)
        kv_q <= 1'b1;
    end
  end

  // Table and working registers need no reset: IDLE reloads them.
  always_ff @(posedge clk) begin
    unique case (state_q)
      IDLE: begin
        if (start) begin
          t_q   <= t_in;
          n_q   <= n_in;
          i_q   <= '0;
          sum_q <= P;
          for (int w = 0; w < 8; w++)
            l_tab[w] <= key[16*w +: 16];
        end
      end
      INIT: begin
        s_tab[i_q] <= sum_q;
        sum_q      <= sum_q + Q;
        if (init_last) begin
          i_q <= '0;
          j_q <= '0;
          k_q <= '0;
          a_q <= '0;
          b_q <= '0;
        end else begin
          i_q <= i_q + 6'd1;
        end
      end
      MIX: begin
        s_tab[i_q] <= a_new;
        l_tab[j_q] <= b_new;
        a_q <= a_new;
        b_q <= b_new;
        i_q <= (i_q + 6'd1 == t_q) ? 6'd0 : i_q + 6'd1;
        j_q <= j_q + 3'd1;
        k_q <= k_q + 7'd1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q == INIT) || (state_q == MIX);
  assign done      = (state_q == DONE);
  assign key_valid = kv_q;
  assign rd_data   = (rd_addr < 6'(TAB)) ? s_tab[rd_addr] : 16'h0000;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed and random checks of rc5_key_expand against a
// straightforward sequential reference of the RC5 key schedule.
module tb_rc5_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   num_rounds;
  logic [127:0] key;
  logic         busy, done, key_valid;
  logic [5:0]   rd_addr;
  logic [15:0]  rd_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_s [34];
  int          exp_t;

  typedef struct {
    logic [127:0] key;
    logic [4:0]   nr;
    int           done_cyc;
  } vec_t;

  vec_t vecs [6];

  localparam logic [127:0] KSEQ = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] KA   = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KB   = 128'hDEADBEEFCAFEF00D5A5AA5A512345678;

  rc5_key_expand #(.MAX_ROUNDS(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_rounds(num_rounds),
    .key(key),
    .busy(busy),
    .done(done),
    .key_valid(key_valid),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rl(input logic [15:0] x,
                                     input int s);
    logic [15:0] y;
    y = (x << s) | (x >> (16 - s));
    return y;
  endfunction

  task automatic model(input logic [127:0] k, input int nr);
    int r, t, n, ii, jj;
    logic [15:0] a, b, tmp;
    logic [15:0] l [8];
    r = (nr > 16) ? 16 : nr;
    t = 2 * r + 2;
    n = 3 * ((t > 8) ? t : 8);
    for (int w = 0; w < 8; w++) l[w] = k[16*w +: 16];
    for (int w = 0; w < t; w++)
      exp_s[w] = 16'(32'hB7E1 + w * 32'h9E37);
    a = 0; b = 0; ii = 0; jj = 0;
    for (int c = 0; c < n; c++) begin
      tmp = exp_s[ii] + a + b;
      a = rl(tmp, 3);
      exp_s[ii] = a;
      tmp = a + b;
      b = rl(l[jj] + tmp, int'(tmp[3:0]));
      l[jj] = b;
      ii = (ii + 1) % t;
      jj = (jj + 1) % 8;
    end
    exp_t = t;
  endtask

  task automatic read_chk(input string name, input int addr,
                          input logic [15:0] exp);
    rd_addr = 6'(addr);
    #1;
    check($sformatf("%s[%0d]", name, addr), 32'(rd_data), 32'(exp));
  endtask

  task automatic run(input logic [127:0] k, input logic [4:0] nr,
                     input int exp_done, input bit hold,
                     input logic [127:0] k2, input logic [4:0] nr2,
                     input bit probe);
    int dcyc, bcnt, ovl;
    model(k, int'(nr));
    @(negedge clk);
    key = k; num_rounds = nr; start = 1'b1;
    dcyc = -1; bcnt = 0; ovl = 0;
    for (int cyc = 1; cyc <= 300 && dcyc < 0; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (hold && cyc == 10) begin
        key = k2; num_rounds = nr2;
      end
      if (cyc == 1) check("kv_clear", 32'(key_valid), 0);
      if (busy) bcnt++;
      if (busy && done) ovl++;
      if (probe && cyc == 27) begin
        read_chk("init_s", 0, 16'hB7E1);
        read_chk("init_s", 1, 16'h5618);
      end
      if (probe && cyc == 28) read_chk("mix0_s", 0, 16'hBF0D);
      if (done) dcyc = cyc;
    end
    check("done_cycle", dcyc, exp_done);
    check("busy_cycles", bcnt, exp_done - 1);
    check("busy_done_overlap", ovl, 0);
    check("kv_at_done", 32'(key_valid), 1);
    read_chk("done_s", 0, exp_s[0]);
    read_chk("done_s", 1, exp_s[1]);
  endtask

  task automatic check_table();
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("kv_idle", 32'(key_valid), 1);
    for (int a = 0; a < exp_t; a++) read_chk("s", a, exp_s[a]);
    for (int a = 34; a < 64; a++) read_chk("oob", a, 16'h0000);
  endtask

  initial begin
    int cnt, r, t, n;
    logic [127:0] rk;
    logic [4:0] rn;

    vecs[0] = '{KSEQ, 5'd31, 137};
    vecs[1] = '{KA,   5'd5,  49};
    vecs[2] = '{KA,   5'd1,  29};
    vecs[3] = '{KB,   5'd12, 105};
    vecs[4] = '{KB,   5'd8,  73};
    vecs[5] = '{KSEQ, 5'd3,  33};

    rst = 1'b0; start = 1'b0; num_rounds = '0; key = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_kv", 32'(key_valid), 0);
    rst = 1'b1;

    run(128'h0, 5'd12, 105, 1'b0, '0, '0, 1'b1);
    check_table();

    run(KSEQ, 5'd0, 27, 1'b0, '0, '0, 1'b0);
    run(KSEQ, 5'd16, 137, 1'b0, '0, '0, 1'b0);
    check_table();

    for (int v = 0; v < 6; v++) begin
      run(vecs[v].key, vecs[v].nr, vecs[v].done_cyc,
          1'b0, '0, '0, 1'b0);
      check_table();
    end

    run(KA, 5'd12, 105, 1'b1, KB, 5'd3, 1'b0);
    run(KB, 5'd3, 33, 1'b0, '0, '0, 1'b0);
    check_table();

    @(negedge clk);
    key = KA; num_rounds = 5'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (66) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_kv", 32'(key_valid), 0);
    check("abort_done", 32'(done), 0);
    rst = 1'b1;
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    run(KA, 5'd12, 105, 1'b0, '0, '0, 1'b0);
    check_table();

    for (int it = 0; it < 200; it++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rn = 5'($urandom_range(0, 31));
      r = (int'(rn) > 16) ? 16 : int'(rn);
      t = 2 * r + 2;
      n = 3 * ((t > 8) ? t : 8);
      run(rk, rn, t + n + 1, 1'b0, '0, '0, 1'b0);
      check_table();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rc5_key_expand.md
# rc5_key_expand

Key-schedule generator for the RC5-16/r/16 accelerator: 16-bit words, 32-bit block, 128-bit key, 0–16 rounds. On `start` it expands the user key into the round-key table S[0..2r+1]. The round engine reads that table through a combinational read port. This block writes the table that the encrypt/decrypt FSM consumes, and must finish before that FSM starts.

## Interface
Parameters:
- `MAX_ROUNDS`, default 16: largest supported round count. The table holds 2*MAX_ROUNDS+2 = 34 words.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-low.
- `start` in, 1: begin expansion. Sampled only in IDLE.
- `num_rounds` in, 5: round count r. Values above MAX_ROUNDS are clamped to MAX_ROUNDS.
- `key` in, 128: user key. Byte k is `key[8k+7:8k]`.
- `busy` out, 1: high during INIT and MIX.
- `done` out, 1: one-cycle pulse when the table is complete.
- `key_valid` out, 1: table valid. High from the `done` cycle until the next accepted `start` or reset.
- `rd_addr` in, 6: table read address.
- `rd_data` out, 16: equals S[rd_addr], combinational. Reads 0 when rd_addr ≥ 34.

## Operation
- Latched on an accepted start:
  - r' = min(num_rounds, MAX_ROUNDS).
  - t = 2r'+2.
  - n = 3*max(t, 8).
  - L[j] = `key[16j+15:16j]` for j = 0..7 (little-endian word packing).
- States and transitions:
  - IDLE: `start` → INIT. Clear `key_valid`, i = 0.
  - INIT: write S[i] = P + i*Q mod 2^16, with P = 0xB7E1 and Q = 0x9E37. Keep a running sum register; do not use a multiplier. Once i = t-1 has been written → MIX, with i = j = A = B = 0 and the iteration counter k = 0.
  - MIX: one iteration per cycle:
    - A' = rotl(S[i] + A + B, 3); write S[i] = A'.
    - B' = rotl(L[j] + A' + B, (A' + B) mod 16); write L[j] = B'.
    - i = (i+1 == t) ? 0 : i+1.
    - j = (j+1) mod 8.
    - When k = n-1 has been processed → DONE.
  - DONE: `done` = 1, `key_valid` = 1 → IDLE.
- Arithmetic: all additions are mod 2^16. Rotation amounts use only the low 4 bits.
- `start` while `busy` or in DONE is ignored. Latched `key` and `num_rounds` are not affected by input changes after acceptance.
- S entries at index ≥ t keep stale contents. The round engine must not read them.
- `rd_data` is undefined (but deterministic) while `busy`.

## Timing
- Accepted `start` at cycle 0 (IDLE):
  - INIT occupies cycles 1..t.
  - MIX occupies cycles t+1..t+n.
  - `done` is high in cycle t+n+1.
  - Back in IDLE at cycle t+n+2, where a new `start` is accepted.
- Example latencies from `start` to the `done` cycle:
  - r = 12: t = 26, n = 78, done at cycle 105.
  - r = 0: t = 2, n = 24, done at cycle 27.
  - r = 16: t = 34, n = 102, done at cycle 137.
- Values after reset (rst = 0 at a clock edge): state IDLE, `busy` = 0, `done` = 0, `key_valid` = 0. S and L contents are unspecified.
- Reset mid-operation aborts immediately, with no `done` pulse and `key_valid` = 0.
- `busy` is combinational from state and rises in cycle 1. `done` and `busy` are never high in the same cycle.

## Test plan
- Zero key, r = 12, `start` pulse:
  - `busy` is high for 104 cycles.
  - `done` is a single pulse at cycle 105.
  - S[0..25] matches the C golden model.
  - After INIT (cycle 26), S[0] = 0xB7E1 and S[1] = 0x5618.
  - MIX iteration 0 writes S[0] = 0xBF0D and L[0] = 0xB7E1.
- Key 0x000102…0F (byte k = k), r = 0 and then r = 16, back-to-back, with `start` re-asserted in the IDLE cycle after `done`:
  - done at cycles 27 and 27+1+137.
  - Tables match the golden model.
  - `key_valid` drops on the second start.
- `num_rounds` = 31:
  - behaves exactly like r = 16 (done at cycle 137, identical table).
  - rd_addr = 34..63 returns 0.
- `start` held high through the whole run, with `key` and `num_rounds` changed mid-run:
  - exactly one expansion using the originally latched values.
  - Because `start` is still high, a second expansion starts at cycle t+n+2.
- `rst` = 0 asserted at MIX cycle 40 of an r = 12 run:
  - next cycle `busy` = 0 and `key_valid` = 0.
  - no `done` pulse.
  - a fresh `start` produces a correct table.
- Randomized keys and r over 200 runs: every table entry and the `done` latency t+n+1 match the model.
